// File: rtl/ddr_line_wb_slave_if.sv
// Wishbone classic bus carrying one 512-bit cache line per transaction
// between the cache arbiter's DDR-side master and the line store.
interface ddr_line_wb_slave_if;
    logic [31:0]  addr;
    logic [511:0] din;
    logic [511:0] dout;
    logic [63:0]  dm;
    logic         we;
    logic         cyc;
    logic         stb;
    logic         ack;

    modport master (output addr, din, dm, we, cyc, stb, input dout, ack);
    modport slave  (input addr, din, dm, we, cyc, stb, output dout, ack);
endinterface

// File: rtl/ddr_line_wb_slave.sv
// Wishbone line slave standing in for the DDR controller: each 512-bit line
// lives in block RAM as eight 64-bit beats, with optional access latency.
module ddr_line_wb_slave #(
    parameter int unsigned LINE_ADDR_BITS = 10,
    parameter int unsigned EXTRA_LATENCY  = 0
) (
    input logic                clk,
    input logic                rst,
    ddr_line_wb_slave_if.slave bus
);
    localparam int unsigned WORD_ADDR_BITS = LINE_ADDR_BITS + 3;
    localparam logic [7:0]  LAST_WAIT      = 8'(EXTRA_LATENCY - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_CAP, S_ACK} state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [LINE_ADDR_BITS-1:0]   r_line;
    logic                        r_we;
    logic [511:0]                r_din;
    logic [63:0]                 r_dm;
    logic [2:0]                  r_beat;
    logic [7:0]                  r_wait;
    logic [447:0]                r_stage;
    logic [511:0]                r_dout;
    logic [63:0]                 r_rdata;
    logic [63:0]                 r_mem [0:(1 << WORD_ADDR_BITS)-1];

    logic                        w_req;
    logic [WORD_ADDR_BITS-1:0]   w_ram_addr;
    logic                        w_ram_we;
    logic [63:0]                 w_ram_wdata;
    logic [7:0]                  w_ram_be;
    logic [2:0]                  w_prev_beat;
    logic                        w_unused_addr;

    assign w_req         = bus.cyc & bus.stb;
    assign w_ram_addr    = {r_line, r_beat};
    assign w_ram_wdata   = r_din[{r_beat, 6'd0} +: 64];
    assign w_ram_be      = r_dm[{r_beat, 3'd0} +: 8];
    assign w_prev_beat   = r_beat - 3'd1;
    assign w_unused_addr = ^bus.addr;

    // A beat is only committed while the cycle is still live and not in reset,
    // so an abort or reset edge never writes the beat in flight.
    assign w_ram_we = rst && bus.cyc && r_we && (r_state == S_XFER);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req) w_next = (EXTRA_LATENCY > 0) ? S_WAIT : S_XFER;
            S_WAIT: begin
                if (!bus.cyc)                w_next = S_IDLE;
                else if (r_wait == LAST_WAIT) w_next = S_XFER;
            end
            S_XFER: begin
                if (!bus.cyc)             w_next = S_IDLE;
                else if (r_beat == 3'd7)  w_next = r_we ? S_ACK : S_CAP;
            end
            S_CAP:  w_next = bus.cyc ? S_ACK : S_IDLE;
            S_ACK:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ack  = (r_state == S_ACK);
        bus.dout = r_dout;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_beat <= '0;
            r_wait <= '0;
            r_dout <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_line <= bus.addr[6 +: LINE_ADDR_BITS];
                        r_we   <= bus.we;
                        r_din  <= bus.din;
                        r_dm   <= bus.dm;
                        r_beat <= '0;
                        r_wait <= '0;
                    end
                end
                S_WAIT: r_wait <= r_wait + 8'd1;
                S_XFER: begin
                    r_beat <= r_beat + 3'd1;
                    // RAM data lags the address by one cycle: stage the previous beat.
                    for (int unsigned b = 0; b < 7; b++) begin
                        if (r_beat != 3'd0 && w_prev_beat == 3'(b))
                            r_stage[64*b +: 64] <= r_rdata;
                    end
                end
                S_CAP: if (bus.cyc) r_dout <= {r_rdata, r_stage};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (w_ram_be[i]) r_mem[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
            end
        end
        r_rdata <= r_mem[w_ram_addr];
    end
endmodule

// File: tb/tb_ddr_line_wb_slave.sv
// Self-checking bench for ddr_line_wb_slave: directed vector table, corner
// sequences and randomized traffic against a line-level reference model.
module tb_ddr_line_wb_slave;
    localparam int          LAB  = 10;
    localparam int          NV   = 13;
    localparam logic [63:0] ONES = '1;

    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [511:0] din;
        logic [63:0]  dm;
        int           exp_lat;
        logic [511:0] exp_dout;
    } vec_t;

    logic         clk  = 1'b0;
    logic         rst0 = 1'b0;
    logic         rst5 = 1'b0;
    logic [31:0]  t_addr [2];
    logic [511:0] t_din  [2];
    logic [63:0]  t_dm   [2];
    logic         t_we   [2];
    logic         t_cyc  [2];
    logic         t_stb  [2];

    int           n_checks = 0;
    int           n_errors = 0;
    int           lat_of [2] = '{0, 5};
    logic [511:0] ref_mem [2][1 << LAB];
    logic [511:0] ref_dout [2];
    vec_t         tv [NV];

    always #5 clk = ~clk;

    ddr_line_wb_slave_if bus0 ();
    ddr_line_wb_slave_if bus5 ();

    assign bus0.addr = t_addr[0];
    assign bus0.din  = t_din[0];
    assign bus0.dm   = t_dm[0];
    assign bus0.we   = t_we[0];
    assign bus0.cyc  = t_cyc[0];
    assign bus0.stb  = t_stb[0];
    assign bus5.addr = t_addr[1];
    assign bus5.din  = t_din[1];
    assign bus5.dm   = t_dm[1];
    assign bus5.we   = t_we[1];
    assign bus5.cyc  = t_cyc[1];
    assign bus5.stb  = t_stb[1];

    ddr_line_wb_slave #(.LINE_ADDR_BITS(LAB), .EXTRA_LATENCY(0)) u_dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    ddr_line_wb_slave #(.LINE_ADDR_BITS(LAB), .EXTRA_LATENCY(5)) u_dut5 (
        .clk (clk),
        .rst (rst5),
        .bus (bus5)
    );

    function automatic logic get_ack(input int sel);
        return (sel == 0) ? bus0.ack : bus5.ack;
    endfunction

    function automatic logic [511:0] get_dout(input int sel);
        return (sel == 0) ? bus0.dout : bus5.dout;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] pat(input logic [7:0] base, input logic [7:0] step);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = base + step * 8'(i);
        return r;
    endfunction

    function automatic logic [511:0] fill(input logic [7:0] b);
        return {64{b}};
    endfunction

    function automatic logic [511:0] merge(input logic [511:0] old, input logic [511:0] din,
                                           input logic [63:0] dm);
        logic [511:0] r;
        r = old;
        for (int i = 0; i < 64; i++) if (dm[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, optionally scrambling the bus after acceptance; lat = -1 on timeout.
    task automatic run_txn(input int sel, input bit we, input logic [31:0] addr,
                           input logic [511:0] din, input logic [63:0] dm,
                           input bit scramble, output int lat);
        @(negedge clk);
        t_we[sel] = we; t_addr[sel] = addr; t_din[sel] = din; t_dm[sel] = dm;
        t_cyc[sel] = 1'b1; t_stb[sel] = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (get_ack(sel) === 1'b1) begin
                lat = n;
                break;
            end
            if (scramble) begin
                t_addr[sel] = $urandom;
                t_din[sel]  = rand512();
                t_dm[sel]   = {$urandom, $urandom};
                t_we[sel]   = 1'($urandom_range(0, 1));
                t_stb[sel]  = 1'($urandom_range(0, 1));
            end
        end
        t_cyc[sel] = 1'b0; t_stb[sel] = 1'b0;
        @(negedge clk);
        chk_int($sformatf("dut%0d_ack_single", lat_of[sel]), (get_ack(sel) === 1'b0) ? 0 : 1, 0);
    endtask

    task automatic txn(input int sel, input bit we, input logic [31:0] addr,
                       input logic [511:0] din, input logic [63:0] dm, input bit scramble);
        int lat;
        int line;
        line = int'(addr[6 +: LAB]);
        run_txn(sel, we, addr, din, dm, scramble, lat);
        chk_int($sformatf("dut%0d_%s_latency", lat_of[sel], we ? "wr" : "rd"), lat,
                lat_of[sel] + (we ? 9 : 10));
        if (we) ref_mem[sel][line] = merge(ref_mem[sel][line], din, dm);
        else    ref_dout[sel] = ref_mem[sel][line];
        chk_vec($sformatf("dut%0d_%s_line%0d", lat_of[sel], we ? "dout_after_wr" : "rd_data", line),
                get_dout(sel), ref_dout[sel]);
    endtask

    // Drop cyc so that it is sampled low at edge 'drop' after acceptance; returns just after that edge.
    task automatic abort_txn(input int sel, input bit we, input logic [31:0] addr,
                             input logic [511:0] din, input logic [63:0] dm,
                             input int drop, input string name);
        int seen;
        int nb;
        int line;
        logic [63:0] m;
        seen = 0;
        m    = '0;
        line = int'(addr[6 +: LAB]);
        @(negedge clk);
        t_we[sel] = we; t_addr[sel] = addr; t_din[sel] = din; t_dm[sel] = dm;
        t_cyc[sel] = 1'b1; t_stb[sel] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= drop; n++) begin
            @(negedge clk);
            if (get_ack(sel) !== 1'b0) seen++;
        end
        t_cyc[sel] = 1'b0; t_stb[sel] = 1'b0;
        @(posedge clk);
        #1;
        if (get_ack(sel) !== 1'b0) seen++;
        chk_int({name, "_no_ack"}, seen, 0);
        chk_vec({name, "_dout_kept"}, get_dout(sel), ref_dout[sel]);
        if (we) begin
            nb = drop - 1 - lat_of[sel];
            for (int b = 0; b < 8; b++) if (b < nb) m[8*b +: 8] = dm[8*b +: 8];
            ref_mem[sel][line] = merge(ref_mem[sel][line], din, m);
        end
    endtask

    task automatic random_phase(input int sel);
        logic [31:0] a;
        logic [63:0] m;
        int pick;
        for (int l = 0; l < 8; l++) txn(sel, 1'b1, {16'h0, 10'(l), 6'h0}, rand512(), ONES, 1'b0);
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            a[6 +: LAB] = 10'($urandom_range(0, 7));
            pick = $urandom_range(0, 3);
            m = (pick == 0) ? 64'h0 : (pick == 1) ? ONES : {$urandom, $urandom};
            txn(sel, 1'($urandom_range(0, 1)), a, rand512(), m, 1'b1);
        end
    endtask

    initial begin
        logic [511:0] p_inc, p_part, p_b, p_c, p_d, exp, cm;
        int lat, lat2, seen, bad;

        for (int s = 0; s < 2; s++) begin
            t_addr[s] = '0; t_din[s] = '0; t_dm[s] = '0;
            t_we[s] = 1'b0; t_cyc[s] = 1'b0; t_stb[s] = 1'b0;
            ref_dout[s] = '0;
        end

        p_inc  = pat(8'h00, 8'h01);
        p_part = p_inc;
        p_part[63:0] = {8{8'hAA}};
        p_b = pat(8'h11, 8'h07);
        p_c = pat(8'hC3, 8'h05);
        p_d = pat(8'h5A, 8'h0D);

        tv[0]  = '{we:1'b1, addr:32'h0000_0040, din:p_inc,       dm:ONES,  exp_lat:9,  exp_dout:'0};
        tv[1]  = '{we:1'b0, addr:32'h0000_0040, din:'0,          dm:'0,    exp_lat:10, exp_dout:p_inc};
        tv[2]  = '{we:1'b1, addr:32'h0000_0040, din:fill(8'hAA), dm:64'hFF, exp_lat:9, exp_dout:p_inc};
        tv[3]  = '{we:1'b0, addr:32'h0000_0040, din:'0,          dm:'0,    exp_lat:10, exp_dout:p_part};
        tv[4]  = '{we:1'b1, addr:32'h0000_0080, din:p_b,         dm:ONES,  exp_lat:9,  exp_dout:p_part};
        tv[5]  = '{we:1'b1, addr:32'h0000_0080, din:fill(8'hFF), dm:'0,    exp_lat:9,  exp_dout:p_part};
        tv[6]  = '{we:1'b0, addr:32'h0000_0080, din:'0,          dm:'0,    exp_lat:10, exp_dout:p_b};
        tv[7]  = '{we:1'b1, addr:32'h0001_0040, din:p_c,         dm:ONES,  exp_lat:9,  exp_dout:p_b};
        tv[8]  = '{we:1'b0, addr:32'h0000_0040, din:'0,          dm:'0,    exp_lat:10, exp_dout:p_c};
        tv[9]  = '{we:1'b0, addr:32'hFFFF_007F, din:'0,          dm:'0,    exp_lat:10, exp_dout:p_c};
        tv[10] = '{we:1'b1, addr:32'h0000_0240, din:p_d,         dm:ONES,  exp_lat:9,  exp_dout:p_c};
        tv[11] = '{we:1'b0, addr:32'h0000_0240, din:'0,          dm:'0,    exp_lat:10, exp_dout:p_d};
        tv[12] = '{we:1'b0, addr:32'h0000_0080, din:'0,          dm:'0,    exp_lat:10, exp_dout:p_b};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b1; rst5 = 1'b1;
        chk_int("reset_ack0", (bus0.ack === 1'b0) ? 0 : 1, 0);
        chk_int("reset_ack5", (bus5.ack === 1'b0) ? 0 : 1, 0);
        chk_vec("reset_dout0", bus0.dout, '0);
        chk_vec("reset_dout5", bus5.dout, '0);

        seen = 0;
        t_stb[0] = 1'b1; t_stb[1] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus0.ack !== 1'b0 || bus5.ack !== 1'b0) seen++;
        end
        t_stb[0] = 1'b0; t_stb[1] = 1'b0;
        chk_int("no_ack_without_cyc", seen, 0);

        for (int k = 0; k < NV; k++) begin
            run_txn(0, tv[k].we, tv[k].addr, tv[k].din, tv[k].dm, 1'b1, lat);
            chk_int($sformatf("vec%0d_latency", k), lat, tv[k].exp_lat);
            chk_vec($sformatf("vec%0d_dout", k), bus0.dout, tv[k].exp_dout);
            if (tv[k].we)
                ref_mem[0][tv[k].addr[6 +: LAB]] = merge(ref_mem[0][tv[k].addr[6 +: LAB]], tv[k].din, tv[k].dm);
            else
                ref_dout[0] = ref_mem[0][tv[k].addr[6 +: LAB]];
        end

        abort_txn(0, 1'b1, 32'h40, fill(8'h55), ONES, 4, "abort_wr");
        txn(0, 1'b0, 32'h40, '0, '0, 1'b0);

        // Hold cyc&stb across the ack: the second read must start only after IDLE.
        @(negedge clk);
        t_we[0] = 1'b0; t_addr[0] = 32'h40; t_cyc[0] = 1'b1; t_stb[0] = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus0.ack === 1'b1) begin lat = n; break; end
        end
        chk_int("hold_first_latency", lat, 10);
        ref_dout[0] = ref_mem[0][1];
        chk_vec("hold_first_data", bus0.dout, ref_dout[0]);
        t_addr[0] = 32'h80;
        bad = 0; lat2 = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus0.ack === 1'b1) begin lat2 = n; break; end
            if (bus0.dout !== ref_dout[0]) bad++;
        end
        chk_int("hold_second_latency", lat2, 11);
        chk_int("hold_dout_stable", bad, 0);
        ref_dout[0] = ref_mem[0][2];
        chk_vec("hold_second_data", bus0.dout, ref_dout[0]);
        t_cyc[0] = 1'b0; t_stb[0] = 1'b0;
        @(negedge clk);
        chk_int("hold_ack_single", (bus0.ack === 1'b0) ? 0 : 1, 0);

        abort_txn(0, 1'b0, 32'h40, '0, '0, 9, "abort_cap");
        txn(0, 1'b0, 32'h40, '0, '0, 1'b0);

        // Reset sampled at edge 5 of a write: beats 0..3 persist, transaction abandoned.
        @(negedge clk);
        t_we[0] = 1'b1; t_addr[0] = 32'h240; t_din[0] = fill(8'h77); t_dm[0] = ONES;
        t_cyc[0] = 1'b1; t_stb[0] = 1'b1;
        @(posedge clk);
        seen = 0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (bus0.ack !== 1'b0) seen++;
        end
        rst0 = 1'b0; t_cyc[0] = 1'b0; t_stb[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst0 = 1'b1;
        if (bus0.ack !== 1'b0) seen++;
        chk_int("rstmid_no_ack", seen, 0);
        chk_vec("rstmid_dout_cleared", bus0.dout, '0);
        run_txn(0, 1'b0, 32'h240, '0, '0, 1'b0, lat);
        chk_int("rstmid_read_latency", lat, 10);
        exp = p_d;
        exp[255:0] = {32{8'h77}};
        cm = '1;
        cm[319:256] = '0;
        chk_vec("rstmid_partial_line", bus0.dout & cm, exp & cm);
        txn(0, 1'b0, 32'h80, '0, '0, 1'b0);

        txn(1, 1'b1, 32'h40, p_inc, ONES, 1'b1);
        txn(1, 1'b0, 32'h40, '0, '0, 1'b1);
        abort_txn(1, 1'b0, 32'h40, '0, '0, 3, "abort_wait");
        txn(1, 1'b0, 32'h40, '0, '0, 1'b0);
        abort_txn(1, 1'b1, 32'h40, fill(8'h55), ONES, 9, "abort_wr_lat");
        txn(1, 1'b0, 32'h40, '0, '0, 1'b0);

        random_phase(0);
        random_phase(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
